// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg
//   Shared definitions for the timer scheduler: FSM state encoding and the
//   default requester count / counter width used by the interface and top.
package timer_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/timer_sched_if.sv
// timer_sched_if
//   Requester-side bus of the timer scheduler.
//   master : drives tick, req, load_value; observes grant, done, busy, cur_count
//   slave  : the scheduler itself (opposite directions)
interface timer_sched_if
   import timer_sched_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
);
   logic                    tick;
   logic [NREQ-1:0]         req;
   logic [NREQ*WIDTH-1:0]   load_value;
   logic [NREQ-1:0]         grant;
   logic [NREQ-1:0]         done;
   logic                    busy;
   logic [WIDTH-1:0]        cur_count;

   modport master (
      output tick, req, load_value,
      input  grant, done, busy, cur_count
   );

   modport slave (
      input  tick, req, load_value,
      output grant, done, busy, cur_count
   );
endinterface

// File: rtl/timer_sched_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Searches req starting at
//   (last_owner+1) mod NREQ, wrapping, and returns the first set index.
//   req        : request vector
//   last_owner : index of the previous winner
//   winner     : selected index (0 when valid=0)
//   valid      : at least one request present
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] last_owner,
   output logic [IDXW-1:0] winner,
   output logic            valid
);

   // cand[k] is the k-th index in search order after last_owner
   logic [IDXW-1:0] cand [NREQ];
   logic [NREQ-1:0] cand_req;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi]     = IDXW'((int'(last_owner) + gi + 1) % NREQ);
      assign cand_req[gi] = req[cand[gi]];
   end

   // Walk from the far end back to the nearest so the nearest set
   // candidate is the last assignment and therefore wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            winner = cand[k];
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_sched.sv
// timer_sched
//   One shared down-counter time-multiplexed among NREQ requesters.
//   A round-robin winner is granted in IDLE, its load value is counted down
//   on tick strobes (L+1 ticks to expire), and a one-cycle done pulse is
//   returned. Dropping the request while counting abandons without done.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : timer_sched_if slave (tick, req, load_value -> grant, done,
//           busy, cur_count)
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   timer_sched_if.slave  bus
);

   localparam int IDXW = $clog2(NREQ);

   state_t            state_reg;
   logic [NREQ-1:0]   grant_reg;
   logic [NREQ-1:0]   done_reg;
   logic [WIDTH-1:0]  count_reg;
   logic [IDXW-1:0]   last_owner_reg;

   logic [IDXW-1:0]   winner;
   logic              winner_valid;

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr_pick (
      .req        (bus.req),
      .last_owner (last_owner_reg),
      .winner     (winner),
      .valid      (winner_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         done_reg       <= '0;
         count_reg      <= '0;
         // Pointing at the top index makes requester 0 first in line.
         last_owner_reg <= IDXW'(NREQ - 1);
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= '0;
               if (winner_valid) begin
                  state_reg      <= COUNT;
                  grant_reg      <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                  count_reg      <= bus.load_value[int'(winner)*WIDTH +: WIDTH];
                  last_owner_reg <= winner;
               end
            end
            COUNT: begin
               // Abandon is checked first so it beats a same-cycle expiry.
               if ((bus.req & grant_reg) == '0) begin
                  state_reg <= IDLE;
                  grant_reg <= '0;
               end else if (bus.tick) begin
                  if (count_reg == '0) begin
                     state_reg <= DONE;
                     done_reg  <= grant_reg;
                  end else begin
                     count_reg <= count_reg - {{(WIDTH-1){1'b0}}, 1'b1};
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               grant_reg <= '0;
               done_reg  <= '0;
            end
            default: begin
               state_reg <= IDLE;
               grant_reg <= '0;
               done_reg  <= '0;
            end
         endcase
      end
   end

   assign bus.grant     = grant_reg;
   assign bus.done      = done_reg;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.cur_count = count_reg;

endmodule
